data_req_win: RTL

- Parametrised successor to the single-plane data request generator.
- Generates the complete read-address stream for one convolution layer: every output window × every input channel × every kernel tap, with configurable stride, kernel size and base address.
- Sits between the layer controller (start/stall) and the data block RAM read port.
- Replaces hard-coded 3x3 row offsets with incremental nested counters, adds channel iteration, config checking and start/done handshake.

---
 rtl/data_req_win_pkg.sv | 29 ++
 rtl/data_req_win_win_cnt.sv | 33 +++
 rtl/data_req_win.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/data_req_win_pkg.sv
// Shared constants for the convolution request generators: FSM encoding,
// input-shape field positions and the config legality rule.
package data_req_win_pkg;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_CONFIG = 3'd1;
   localparam logic [2:0] ST_RUN    = 3'd2;
   localparam logic [2:0] ST_DONE   = 3'd3;
   localparam logic [2:0] ST_ERR    = 3'd4;

   localparam int SHAPE_W_LSB   = 0;
   localparam int SHAPE_H_LSB   = 8;
   localparam int SHAPE_C_LSB   = 16;
   localparam int SHAPE_FIELD_W = 8;

   typedef struct packed {
      logic [SHAPE_FIELD_W-1:0] c;
      logic [SHAPE_FIELD_W-1:0] h;
      logic [SHAPE_FIELD_W-1:0] w;
   } shape_t;

   // A layer is unusable if any dimension is empty or the kernel overhangs the plane.
   function automatic logic cfg_illegal(input int unsigned w, input int unsigned h,
                                        input int unsigned c, input int unsigned k,
                                        input int unsigned s);
      return (k == 0) || (s == 0) || (c == 0) || (k > w) || (k > h);
   endfunction

endpackage

// File: rtl/data_req_win_win_cnt.sv
// Wrap counter: advances by step on inc, returns to 0 once the next value
// would pass limit. last flags the final position, wrap is last & inc.
module data_req_win_win_cnt #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   input  logic [WIDTH-1:0] step,
   input  logic [WIDTH-1:0] limit,
   output logic             last,
   output logic             wrap
);

   logic [WIDTH-1:0] value;
   logic [WIDTH:0]   value_nxt;

   assign value_nxt = {1'b0, value} + {1'b0, step};
   assign last      = value_nxt > {1'b0, limit};
   assign wrap      = inc & last;

   always_ff @(posedge clk) begin
      if (!rst) begin
         value <= '0;
      end else if (clr) begin
         value <= '0;
      end else if (inc) begin
         value <= last ? '0 : value_nxt[WIDTH-1:0];
      end
   end

endmodule

// File: rtl/data_req_win.sv
// Read-address generator for one convolution layer: walks every output
// window x channel x kernel tap and issues one RAM read per accepted tap.
//
//   state  | meaning
//   IDLE   | waiting for i_start
//   CONFIG | latch shape/kernel/stride/base, compute plane and row stride
//   RUN    | issue reads; advance on every cycle with o_rden=1
//   DONE   | one-cycle o_done pulse
//   ERR    | one-cycle o_err pulse, no reads issued
module data_req_win
   import data_req_win_pkg::*;
#(
   parameter int ADDR_WIDTH        = 32,
   parameter int REG_WIDTH         = 32,
   parameter int DIM_WIDTH         = 8,
   parameter int KERNEL_SIZE_WIDTH = 3,
   parameter int STRIDE_WIDTH      = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_start,
   input  logic                    i_stall,
   input  logic [REG_WIDTH-1:0]    i_conf_inputshape,
   input  logic [REG_WIDTH-1:0]    i_conf_kernelshape,
   input  logic [STRIDE_WIDTH-1:0] i_cnfx_stride,
   input  logic [ADDR_WIDTH-1:0]   i_conf_baseaddr,
   output logic [ADDR_WIDTH-1:0]   o_addr,
   output logic                    o_rden,
   output logic                    o_busy,
   output logic                    o_done,
   output logic                    o_err,
   output logic [REG_WIDTH-1:0]    dbg_datareq_state,
   output logic [REG_WIDTH-1:0]    dbg_datareq_rdcnt
);

   localparam logic [DIM_WIDTH-1:0]  DIM_ONE  = DIM_WIDTH'(1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
   localparam logic [REG_WIDTH-1:0]  REG_ONE  = REG_WIDTH'(1);

   logic [2:0] state, state_nxt;

   logic [DIM_WIDTH-1:0] cfg_w, cfg_h, cfg_c, cfg_k, cfg_s;
   logic                 cfg_bad;
   logic                 unused_cfg_bits;

   assign cfg_w = i_conf_inputshape[SHAPE_W_LSB +: DIM_WIDTH];
   assign cfg_h = i_conf_inputshape[SHAPE_H_LSB +: DIM_WIDTH];
   assign cfg_c = i_conf_inputshape[SHAPE_C_LSB +: DIM_WIDTH];
   assign cfg_k = DIM_WIDTH'(i_conf_kernelshape[KERNEL_SIZE_WIDTH-1:0]);
   assign cfg_s = DIM_WIDTH'(i_cnfx_stride);

   assign cfg_bad = cfg_illegal(32'(cfg_w), 32'(cfg_h), 32'(cfg_c), 32'(cfg_k), 32'(cfg_s));

   assign unused_cfg_bits = ^{i_conf_inputshape[REG_WIDTH-1:SHAPE_C_LSB+DIM_WIDTH],
                              i_conf_kernelshape[REG_WIDTH-1:KERNEL_SIZE_WIDTH]};

   logic cfg_phase;
   logic accept;
   logic final_tap;

   assign cfg_phase = (state == ST_CONFIG);
   assign accept    = o_rden;

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (i_start) state_nxt = ST_CONFIG;
         ST_CONFIG: state_nxt = cfg_bad ? ST_ERR : ST_RUN;
         ST_RUN:    if (final_tap) state_nxt = ST_DONE;
         ST_DONE:   state_nxt = ST_IDLE;
         ST_ERR:    state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   logic [DIM_WIDTH-1:0]  k_lim, c_lim, x_lim, y_lim, s_dim;
   logic [ADDR_WIDTH-1:0] w_step, s_step, plane, row_stride;

   // Limits hold the last legal counter position; they wrap harmlessly on
   // illegal configs because those never reach RUN.
   always_ff @(posedge clk) begin
      if (!rst) begin
         k_lim      <= '0;
         c_lim      <= '0;
         x_lim      <= '0;
         y_lim      <= '0;
         s_dim      <= '0;
         w_step     <= '0;
         s_step     <= '0;
         plane      <= '0;
         row_stride <= '0;
      end else if (cfg_phase) begin
         k_lim      <= cfg_k - DIM_ONE;
         c_lim      <= cfg_c - DIM_ONE;
         x_lim      <= cfg_w - cfg_k;
         y_lim      <= cfg_h - cfg_k;
         s_dim      <= cfg_s;
         w_step     <= ADDR_WIDTH'(cfg_w);
         s_step     <= ADDR_WIDTH'(i_cnfx_stride);
         plane      <= ADDR_WIDTH'(cfg_w) * ADDR_WIDTH'(cfg_h);
         row_stride <= ADDR_WIDTH'(i_cnfx_stride) * ADDR_WIDTH'(cfg_w);
      end
   end

   logic kx_last, kx_wrap, ky_last, ky_wrap, c_last, c_wrap;
   logic xb_last, xb_wrap, yb_last, yb_wrap;

   data_req_win_win_cnt #(.WIDTH(DIM_WIDTH)) u_kx_cnt (
      .clk(clk), .rst(rst), .clr(cfg_phase), .inc(accept),
      .step(DIM_ONE), .limit(k_lim), .last(kx_last), .wrap(kx_wrap));

   data_req_win_win_cnt #(.WIDTH(DIM_WIDTH)) u_ky_cnt (
      .clk(clk), .rst(rst), .clr(cfg_phase), .inc(kx_wrap),
      .step(DIM_ONE), .limit(k_lim), .last(ky_last), .wrap(ky_wrap));

   data_req_win_win_cnt #(.WIDTH(DIM_WIDTH)) u_c_cnt (
      .clk(clk), .rst(rst), .clr(cfg_phase), .inc(ky_wrap),
      .step(DIM_ONE), .limit(c_lim), .last(c_last), .wrap(c_wrap));

   data_req_win_win_cnt #(.WIDTH(DIM_WIDTH)) u_xb_cnt (
      .clk(clk), .rst(rst), .clr(cfg_phase), .inc(c_wrap),
      .step(s_dim), .limit(x_lim), .last(xb_last), .wrap(xb_wrap));

   data_req_win_win_cnt #(.WIDTH(DIM_WIDTH)) u_yb_cnt (
      .clk(clk), .rst(rst), .clr(cfg_phase), .inc(xb_wrap),
      .step(s_dim), .limit(y_lim), .last(yb_last), .wrap(yb_wrap));

   assign final_tap = yb_wrap;

   // Nested pointers: line = window-row origin, win = window origin,
   // chan = window origin in channel c, row = kernel row ky, addr = tap.
   logic [ADDR_WIDTH-1:0] addr_q, row_ptr, chan_ptr, win_ptr, line_ptr;
   logic [ADDR_WIDTH-1:0] row_nxt, chan_nxt, win_nxt, line_nxt;

   assign row_nxt  = row_ptr  + w_step;
   assign chan_nxt = chan_ptr + plane;
   assign win_nxt  = win_ptr  + s_step;
   assign line_nxt = line_ptr + row_stride;

   always_ff @(posedge clk) begin
      if (!rst) begin
         addr_q   <= '0;
         row_ptr  <= '0;
         chan_ptr <= '0;
         win_ptr  <= '0;
         line_ptr <= '0;
      end else if (cfg_phase) begin
         addr_q   <= i_conf_baseaddr;
         row_ptr  <= i_conf_baseaddr;
         chan_ptr <= i_conf_baseaddr;
         win_ptr  <= i_conf_baseaddr;
         line_ptr <= i_conf_baseaddr;
      end else if (accept) begin
         if (!kx_last) begin
            addr_q <= addr_q + ADDR_ONE;
         end else if (!ky_last) begin
            row_ptr <= row_nxt;
            addr_q  <= row_nxt;
         end else if (!c_last) begin
            chan_ptr <= chan_nxt;
            row_ptr  <= chan_nxt;
            addr_q   <= chan_nxt;
         end else if (!xb_last) begin
            win_ptr  <= win_nxt;
            chan_ptr <= win_nxt;
            row_ptr  <= win_nxt;
            addr_q   <= win_nxt;
         end else if (!yb_last) begin
            line_ptr <= line_nxt;
            win_ptr  <= line_nxt;
            chan_ptr <= line_nxt;
            row_ptr  <= line_nxt;
            addr_q   <= line_nxt;
         end
      end
   end

   logic [REG_WIDTH-1:0] rd_cnt;

   always_ff @(posedge clk) begin
      if (!rst) begin
         rd_cnt <= '0;
      end else if (cfg_phase) begin
         rd_cnt <= '0;
      end else if (accept) begin
         rd_cnt <= rd_cnt + REG_ONE;
      end
   end

   assign o_addr            = addr_q;
   assign o_rden            = (state == ST_RUN) & ~i_stall;
   assign o_busy            = (state == ST_CONFIG) | (state == ST_RUN);
   assign o_done            = (state == ST_DONE);
   assign o_err             = (state == ST_ERR);
   assign dbg_datareq_state = REG_WIDTH'(state);
   assign dbg_datareq_rdcnt = rd_cnt;

endmodule
